// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: command FIFO and result register in front of a 4-bit combinational ALU.
//   clk, rst             : single clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : producer handshake; carries cmd_select, cmd_x, cmd_y
//   alu_select/x/y       : FIFO head driven to the ALU (zero when the FIFO is empty)
//   alu_out              : combinational ALU result, captured on issue
//   res_valid/res_ready  : consumer handshake; carries res_data, res_select, res_tag
//   busy                 : FIFO non-empty or an unconsumed result is held
module alu_cmd_issuer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_select,
  input  logic [WIDTH-1:0]   cmd_x,
  input  logic [WIDTH-1:0]   cmd_y,
  output logic [2:0]         alu_select,
  output logic [WIDTH-1:0]   alu_x,
  output logic [WIDTH-1:0]   alu_y,
  input  logic [2*WIDTH-1:0] alu_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic [2:0]         res_select,
  output logic [TAG_W-1:0]   res_tag,
  output logic               busy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [2:0]       sel_mem [DEPTH];
  logic [WIDTH-1:0] x_mem   [DEPTH];
  logic [WIDTH-1:0] y_mem   [DEPTH];

  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic [TAG_W-1:0]   tag_q;
  logic               res_valid_q;
  logic [2*WIDTH-1:0] res_data_q;
  logic [2:0]         res_select_q;
  logic [TAG_W-1:0]   res_tag_q;

  logic not_empty;
  logic push;
  logic pop;

  assign not_empty = (count_q != '0);
  // Registered-state only: no combinational path from res_ready to cmd_ready.
  assign cmd_ready = (count_q < CntW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // Head is only visible once registered, so an entry pushed into an empty FIFO cannot bypass.
  assign pop       = not_empty && (!res_valid_q || res_ready);

  always_comb begin
    alu_select = '0;
    alu_x      = '0;
    alu_y      = '0;
    if (not_empty) begin
      alu_select = sel_mem[rd_ptr_q];
      alu_x      = x_mem[rd_ptr_q];
      alu_y      = y_mem[rd_ptr_q];
    end
  end

  // Storage needs no reset: it is never observed while count_q is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      sel_mem[wr_ptr_q] <= cmd_select;
      x_mem[wr_ptr_q]   <= cmd_x;
      y_mem[wr_ptr_q]   <= cmd_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tag_q        <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_select_q <= '0;
      res_tag_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);

      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase

      if (pop) begin
        res_valid_q  <= 1'b1;
        res_data_q   <= alu_out;
        res_select_q <= alu_select;
        res_tag_q    <= tag_q;
        tag_q        <= tag_q + TAG_W'(1);
      end else if (res_valid_q && res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_select = res_select_q;
  assign res_tag    = res_tag_q;
  assign busy       = not_empty || res_valid_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed self-checking bench for alu_cmd_issuer, with a behavioural model of the 4-bit ALU.
module tb_alu_cmd_issuer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_select;
  logic [3:0] cmd_x;
  logic [3:0] cmd_y;
  logic [2:0] alu_select;
  logic [3:0] alu_x;
  logic [3:0] alu_y;
  logic [7:0] alu_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_select;
  logic [3:0] res_tag;
  logic       busy;

  int checks = 0;
  int failures = 0;

  alu_cmd_issuer #(
    .WIDTH(4),
    .DEPTH(4),
    .TAG_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_select(cmd_select),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .alu_select(alu_select),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_select(res_select),
    .res_tag   (res_tag),
    .busy      (busy)
  );

  // ALU: 0 add, 1 AND, 2 multiply, anything else 5.
  always_comb begin
    case (alu_select)
      3'd0:    alu_out = {4'b0, alu_x} + {4'b0, alu_y};
      3'd1:    alu_out = {4'b0, alu_x & alu_y};
      3'd2:    alu_out = {4'b0, alu_x} * {4'b0, alu_y};
      default: alu_out = 8'd5;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; everything is sampled and driven 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic drive_cmd(input logic [2:0] s, input logic [3:0] x, input logic [3:0] y);
    cmd_valid = 1'b1;
    cmd_select = s;
    cmd_x = x;
    cmd_y = y;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%0b exp=1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0b exp=0", res_valid); end
    checks++; if ({alu_select, alu_x, alu_y} !== 11'd0) begin failures++; $display("FAIL reset_alu got=%0h exp=0", {alu_select, alu_x, alu_y}); end
    checks++; if ({res_data, res_select, res_tag} !== 15'd0) begin failures++; $display("FAIL reset_res_regs got=%0h exp=0", {res_data, res_select, res_tag}); end
  endtask

  task automatic test_single();
    do_reset();
    res_ready = 1'b1;
    drive_cmd(3'd0, 4'd8, 4'd5);
    step();
    cmd_valid = 1'b0;
    // Accepted but not yet captured: head is on the ALU bus.
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%0b exp=0", res_valid); end
    checks++; if (alu_x !== 4'd8 || alu_y !== 4'd5) begin failures++; $display("FAIL single_alu_head got=%0d,%0d exp=8,5", alu_x, alu_y); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%0b exp=1", busy); end
    step();
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", res_valid); end
    checks++; if (res_data !== 8'd13) begin failures++; $display("FAIL single_data got=%0d exp=13", res_data); end
    checks++; if (res_select !== 3'd0 || res_tag !== 4'd0) begin failures++; $display("FAIL single_sel_tag got=%0d/%0d exp=0/0", res_select, res_tag); end
    step();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%0b/%0b exp=0/0", res_valid, busy); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] sel [4];
    logic [3:0] xs  [4];
    logic [3:0] ys  [4];
    logic [7:0] ex  [4];
    sel = '{3'd1, 3'd2, 3'd2, 3'd5};
    xs  = '{4'd8, 4'd15, 4'd7, 4'd13};
    ys  = '{4'd5, 4'd15, 4'd6, 4'd11};
    // 8 AND 5 is zero; 15*15=225; 7*6=42; select 5 yields 5.
    ex  = '{8'd0, 8'd225, 8'd42, 8'd5};
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", i, cmd_ready); end
        drive_cmd(sel[i], xs[i], ys[i]);
      end else begin
        cmd_valid = 1'b0;
      end
      step();
      if (i >= 1) begin
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%0b exp=1", i - 1, res_valid); end
        checks++; if (res_data !== ex[i-1]) begin failures++; $display("FAIL b2b_data[%0d] got=%0d exp=%0d", i - 1, res_data, ex[i-1]); end
        checks++; if (res_tag !== 4'(i - 1) || res_select !== sel[i-1]) begin failures++; $display("FAIL b2b_tag_sel[%0d] got=%0d/%0d exp=%0d/%0d", i - 1, res_tag, res_select, i - 1, sel[i-1]); end
      end
    end
  endtask

  task automatic test_capacity();
    int accepted;
    accepted = 0;
    do_reset();
    res_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive_cmd(3'd0, 4'(accepted + 1), 4'd1);
      if (cmd_ready === 1'b1) accepted++;
      step();
    end
    cmd_valid = 1'b0;
    checks++; if (accepted != 5) begin failures++; $display("FAIL cap_accepted got=%0d exp=5", accepted); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL cap_ready_low got=%0b exp=0", cmd_ready); end
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL cap_drain_valid[%0d] got=%0b exp=1", k, res_valid); end
      checks++; if (res_data !== 8'(k + 2) || res_tag !== 4'(k)) begin failures++; $display("FAIL cap_drain[%0d] got=%0d/%0d exp=%0d/%0d", k, res_data, res_tag, k + 2, k); end
      if (k == 1) begin
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL cap_ready_back got=%0b exp=1", cmd_ready); end
      end
      step();
    end
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL cap_idle got=%0b/%0b exp=0/0", res_valid, busy); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(3'd0, 4'(i + 1), 4'd0);
      step();
    end
    // Result register holds the first command; two remain queued.
    checks++; if (dut.count_q !== 3'd2) begin failures++; $display("FAIL simul_pre_count got=%0d exp=2", dut.count_q); end
    checks++; if (res_data !== 8'd1 || res_tag !== 4'd0) begin failures++; $display("FAIL simul_held got=%0d/%0d exp=1/0", res_data, res_tag); end
    res_ready = 1'b1;
    drive_cmd(3'd0, 4'd4, 4'd0);
    step();
    cmd_valid = 1'b0;
    checks++; if (dut.count_q !== 3'd2) begin failures++; $display("FAIL simul_count got=%0d exp=2", dut.count_q); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL simul_ready got=%0b exp=1", cmd_ready); end
    for (int k = 1; k < 4; k++) begin
      checks++; if (res_valid !== 1'b1 || res_data !== 8'(k + 1) || res_tag !== 4'(k)) begin failures++; $display("FAIL simul_order[%0d] got=%0b/%0d/%0d exp=1/%0d/%0d", k, res_valid, res_data, res_tag, k + 1, k); end
      step();
    end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL simul_idle got=%0b exp=0", res_valid); end
  endtask

  task automatic test_tag_wrap();
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 17) drive_cmd(3'd0, 4'(i), 4'd1);
      else cmd_valid = 1'b0;
      step();
      if (i >= 1) begin
        checks++; if (res_valid !== 1'b1 || res_tag !== 4'((i - 1) % 16) || res_data !== 8'(((i - 1) % 16) + 1)) begin failures++; $display("FAIL wrap[%0d] got=%0b/%0d/%0d exp=1/%0d/%0d", i - 1, res_valid, res_tag, res_data, (i - 1) % 16, ((i - 1) % 16) + 1); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(3'd2, 4'(i + 3), 4'd2);
      step();
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%0b/%0b exp=0/0", res_valid, busy); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%0b exp=1", cmd_ready); end
    checks++; if ({alu_select, alu_x, alu_y} !== 11'd0) begin failures++; $display("FAIL midrst_alu got=%0h exp=0", {alu_select, alu_x, alu_y}); end
    res_ready = 1'b1;
    drive_cmd(3'd0, 4'd3, 4'd4);
    step();
    cmd_valid = 1'b0;
    step();
    checks++; if (res_valid !== 1'b1 || res_tag !== 4'd0 || res_data !== 8'd7) begin failures++; $display("FAIL midrst_first got=%0b/%0d/%0d exp=1/0/7", res_valid, res_tag, res_data); end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_select = '0;
    cmd_x = '0;
    cmd_y = '0;
    res_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_capacity();
    test_simultaneous();
    test_tag_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
